// File: rtl/watch_mode_ctrl_if.sv
// watch_mode_ctrl_if: raw buttons in, counter controls and display blanking out
interface watch_mode_ctrl_if;
    logic       btn_mode;
    logic       btn_start;
    logic       btn_up;
    logic       run_en;
    logic       clr;
    logic       inc_h;
    logic       inc_m;
    logic [7:0] blank_mask;
    logic [1:0] mode;
    modport master (output btn_mode, btn_start, btn_up,
                    input run_en, clr, inc_h, inc_m, blank_mask, mode);
    modport slave  (input btn_mode, btn_start, btn_up,
                    output run_en, clr, inc_h, inc_m, blank_mask, mode);
endinterface

// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: debounced RUN/STOP/SET_H/SET_M panel FSM with UP auto-repeat and set-digit blink
module watch_mode_ctrl #(
    parameter int DEBOUNCE      = 20,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 200,
    parameter int BLINK_HALF    = 250
) (
    input  logic             clk,
    input  logic             rst,
    watch_mode_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'b00, STOP = 2'b01, SET_H = 2'b10, SET_M = 2'b11} state_t;
    localparam int DW   = $clog2(DEBOUNCE + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int BW   = $clog2(BLINK_HALF + 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);

    logic [2:0]    raw, s1, s2, db, db_q, armed, press;
    logic [DW-1:0] dcnt [3];
    state_t        state, state_n;
    logic          run_en, clr, inc_h, inc_m, rep_act, rep_first, blanked;
    logic          run_en_n, clr_n, inc_h_n, inc_m_n, rep_act_n, rep_first_n, blanked_n;
    logic [7:0]    mask, mask_n;
    logic [RW-1:0] rep_cnt, rep_cnt_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          ev_mode, ev_start, ev_up, up_press, changed, rep_fire, up_strobe;
    logic          blink_clr, blink_wrap;

    assign raw = {bus.btn_up, bus.btn_start, bus.btn_mode};

    always_ff @(posedge clk) begin
        s1 <= raw;
        s2 <= s1;
    end

    // armed keeps a button held through reset from producing a press until it is released
    always_ff @(posedge clk) begin
        if (rst) begin
            db    <= '0;
            db_q  <= '0;
            armed <= '0;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            db_q  <= db;
            armed <= armed | ~s2;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) dcnt[i] <= '0;
                else if (dcnt[i] == DB_LAST) begin
                    db[i]   <= s2[i];
                    dcnt[i] <= '0;
                end else dcnt[i] <= dcnt[i] + 1'b1;
            end
        end
    end

    assign press = db & ~db_q & armed;

    always_comb begin
        ev_mode     = press[0];
        ev_start    = press[1] & ~press[0];
        ev_up       = press[2] & ~press[1] & ~press[0];
        state_n     = ev_mode ? (state == SET_H ? SET_M : state == SET_M ? RUN : SET_H) :
                      (ev_start & ~state[1]) ? (state == RUN ? STOP : RUN) : state;
        changed     = state_n != state;
        up_press    = ev_up & state[1];
        rep_fire    = rep_act & db[2] & ~changed & (rep_cnt == (rep_first ? DELAY_LAST : PERIOD_LAST));
        up_strobe   = up_press | rep_fire;
        run_en_n    = state_n == RUN;
        clr_n       = ev_up & (state == STOP);
        inc_h_n     = up_strobe & (state == SET_H);
        inc_m_n     = up_strobe & (state == SET_M);
        rep_act_n   = up_press | (rep_act & db[2] & ~changed);
        rep_first_n = up_press ? 1'b1 : rep_fire ? 1'b0 : rep_first;
        rep_cnt_n   = (~rep_act_n | up_press | rep_fire) ? '0 : rep_cnt + 1'b1;
        // holding UP pins the blink at the start of its visible half
        blink_clr   = state_n[1] & (changed | db[2]);
        blink_wrap  = blink_cnt == BLINK_LAST;
        blink_cnt_n = (~state_n[1] | blink_clr | blink_wrap) ? '0 : blink_cnt + 1'b1;
        blanked_n   = (~state_n[1] | blink_clr) ? 1'b0 : blink_wrap ? ~blanked : blanked;
        mask_n      = ~blanked_n ? 8'h00 : state_n == SET_H ? 8'hC0 : 8'h30;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            run_en    <= 1'b1;
            clr       <= 1'b0;
            inc_h     <= 1'b0;
            inc_m     <= 1'b0;
            mask      <= '0;
            rep_act   <= 1'b0;
            rep_first <= 1'b0;
            rep_cnt   <= '0;
            blink_cnt <= '0;
            blanked   <= 1'b0;
        end else begin
            state     <= state_n;
            run_en    <= run_en_n;
            clr       <= clr_n;
            inc_h     <= inc_h_n;
            inc_m     <= inc_m_n;
            mask      <= mask_n;
            rep_act   <= rep_act_n;
            rep_first <= rep_first_n;
            rep_cnt   <= rep_cnt_n;
            blink_cnt <= blink_cnt_n;
            blanked   <= blanked_n;
        end
    end

    assign bus.mode       = state;
    assign bus.run_en     = run_en;
    assign bus.clr        = clr;
    assign bus.inc_h      = inc_h;
    assign bus.inc_m      = inc_m;
    assign bus.blank_mask = mask;
endmodule

// File: tb/tb_watch_mode_ctrl.sv
// tb_watch_mode_ctrl: scoreboard bench; a timing-level model predicts every output change
module tb_watch_mode_ctrl;
    localparam int DB = 20, RD = 500, RP = 200, BH = 250;

    typedef struct packed {
        int         cyc;
        logic [1:0] mode;
        logic       run_en;
        logic       clr;
        logic       inc_h;
        logic       inc_m;
        logic [7:0] mask;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    watch_mode_ctrl_if bus();
    watch_mode_ctrl #(.DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .BLINK_HALF(BH))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  vectors = 0, errors = 0, cyc = 0;
    bit  started = 0, mon_init = 0, saw_c0 = 0, saw_30 = 0;
    int  n_inc_h = 0, n_inc_m = 0, n_clr = 0;

    function automatic bit is_event(ev_t a, ev_t p);
        return a.clr | a.inc_h | a.inc_m | (a.mode != p.mode) | (a.run_en != p.run_en) | (a.mask != p.mask);
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: debounced levels from the raw sample log, then mode table,
    // repeat timing as offsets from the press strobe, blink as elapsed time since its reference
    logic [2:0] raw_log[$];
    logic [2:0] lvl = 0, lvl_q = 0, m_armed = 0;
    int         run_m[3];
    int         m_mode = 0, rep_t0 = -1, blink_ref = 0;
    ev_t        prev_e;

    always @(posedge clk) begin
        logic [2:0] syn, pr;
        int         nm, k;
        bit         pm, ps, pu, strobe, fire;
        ev_t        e;
        cyc++;
        syn = (cyc >= 3) ? raw_log[cyc-3] : 3'b000;
        raw_log.push_back({bus.btn_up, bus.btn_start, bus.btn_mode});
        e.cyc = cyc;
        if (rst) begin
            m_mode = 0; lvl = 0; lvl_q = 0; m_armed = 0; rep_t0 = -1; blink_ref = 0;
            for (int b = 0; b < 3; b++) run_m[b] = 0;
            e.mode = 2'd0; e.run_en = 1; e.clr = 0; e.inc_h = 0; e.inc_m = 0; e.mask = 8'h00;
            if (!started) prev_e = e;
            started = 1;
        end else begin
            pr = lvl & ~lvl_q & m_armed;
            pm = pr[0];
            ps = pr[1] & ~pm;
            pu = pr[2] & ~pm & ~ps;
            nm = m_mode;
            if (pm) nm = (m_mode == 2) ? 3 : (m_mode == 3) ? 0 : 2;
            else if (ps && m_mode < 2) nm = m_mode ^ 1;
            strobe = pu && m_mode >= 2;
            fire = 0;
            if (rep_t0 >= 0 && lvl[2] && nm == m_mode) begin
                k = cyc - rep_t0;
                fire = (k == RD) || (k > RD && (k - RD) % RP == 0);
            end
            e.mode   = 2'(nm);
            e.run_en = nm == 0;
            e.clr    = pu && m_mode == 1;
            e.inc_h  = m_mode == 2 && (strobe || fire);
            e.inc_m  = m_mode == 3 && (strobe || fire);
            if (strobe) rep_t0 = cyc;
            else if (!lvl[2] || nm != m_mode) rep_t0 = -1;
            if (nm >= 2 && (nm != m_mode || lvl[2])) blink_ref = cyc;
            e.mask = (nm >= 2 && ((cyc - blink_ref) / BH) % 2 == 1) ? (nm == 2 ? 8'hC0 : 8'h30) : 8'h00;
            m_mode = nm;
            lvl_q = lvl;
            for (int b = 0; b < 3; b++) begin
                m_armed[b] = m_armed[b] | ~syn[b];
                if (syn[b] != lvl[b]) begin
                    run_m[b]++;
                    if (run_m[b] == DB) begin
                        lvl[b] = syn[b];
                        run_m[b] = 0;
                    end
                end else run_m[b] = 0;
            end
        end
        if (is_event(e, prev_e)) exp_q.push_back(e);
        prev_e = e;
    end

    ev_t mon_prev;
    always @(negedge clk) begin
        ev_t cur, x;
        if (started) begin
            cur.cyc = cyc; cur.mode = bus.mode; cur.run_en = bus.run_en; cur.clr = bus.clr;
            cur.inc_h = bus.inc_h; cur.inc_m = bus.inc_m; cur.mask = bus.blank_mask;
            if (!mon_init) begin
                mon_init = 1;
                vectors++;
                if (cur.mode != 0 || cur.run_en != 1 || cur.clr || cur.inc_h || cur.inc_m || cur.mask != 0) begin
                    errors++;
                    $display("FAIL reset_state: got mode=%0d run_en=%0b clr=%0b inc_h=%0b inc_m=%0b mask=%h, expected mode=0 run_en=1 strobes=0 mask=00",
                             cur.mode, cur.run_en, cur.clr, cur.inc_h, cur.inc_m, cur.mask);
                end
            end else if (is_event(cur, mon_prev)) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got cyc=%0d mode=%0d run_en=%0b clr=%0b inc_h=%0b inc_m=%0b mask=%h, expected no change",
                             cur.cyc, cur.mode, cur.run_en, cur.clr, cur.inc_h, cur.inc_m, cur.mask);
                end else begin
                    x = exp_q.pop_front();
                    if (x != cur) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d mode=%0d run_en=%0b clr=%0b inc_h=%0b inc_m=%0b mask=%h, expected cyc=%0d mode=%0d run_en=%0b clr=%0b inc_h=%0b inc_m=%0b mask=%h",
                                 cur.cyc, cur.mode, cur.run_en, cur.clr, cur.inc_h, cur.inc_m, cur.mask,
                                 x.cyc, x.mode, x.run_en, x.clr, x.inc_h, x.inc_m, x.mask);
                    end
                end
            end
            n_inc_h += int'(cur.inc_h);
            n_inc_m += int'(cur.inc_m);
            n_clr   += int'(cur.clr);
            if (cur.mask == 8'hC0) saw_c0 = 1;
            if (cur.mask == 8'h30) saw_30 = 1;
            mon_prev = cur;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(int b, logic v);
        if (b == 0) bus.btn_mode = v;
        else if (b == 1) bus.btn_start = v;
        else bus.btn_up = v;
    endtask

    task automatic hold(int b, int n);
        set_btn(b, 1'b1);
        tick(n);
        set_btn(b, 1'b0);
        tick(40);
    endtask

    initial begin
        int h0, m0, c0, b, b2;
        bus.btn_mode = 0; bus.btn_start = 0; bus.btn_up = 0;
        tick(3);
        rst = 0;
        tick(1000);
        chk("idle_mode", int'(bus.mode), 0);
        chk("idle_run_en", int'(bus.run_en), 1);
        chk("idle_strobes", n_inc_h + n_inc_m + n_clr, 0);

        set_btn(1, 1); tick(5); set_btn(1, 0); tick(40);
        chk("bounce_ignored", int'(bus.mode), 0);
        set_btn(1, 1);
        tick(22);
        chk("latency_before", int'(bus.mode), 0);
        tick(1);
        chk("latency_mode", int'(bus.mode), 1);
        chk("latency_run_en", int'(bus.run_en), 0);
        tick(17); set_btn(1, 0); tick(40);
        hold(1, 40);
        chk("start_back_run", int'(bus.mode), 0);

        hold(0, 40);
        chk("mode_set_h", int'(bus.mode), 2);
        tick(600);
        chk("blink_c0_seen", int'(saw_c0), 1);
        h0 = n_inc_h;
        hold(2, 1000);
        chk("inc_h_repeat_count", n_inc_h - h0, 4);
        hold(0, 40);
        chk("mode_set_m", int'(bus.mode), 3);
        tick(600);
        chk("blink_30_seen", int'(saw_30), 1);

        hold(0, 40);
        hold(1, 40);
        chk("mode_stop", int'(bus.mode), 1);
        c0 = n_clr;
        hold(2, 2000);
        chk("clr_once", n_clr - c0, 1);
        chk("stop_kept", int'(bus.mode), 1);
        chk("stop_run_en", int'(bus.run_en), 0);

        hold(1, 40);
        chk("run_again", int'(bus.mode), 0);
        set_btn(0, 1); set_btn(1, 1); tick(40); set_btn(0, 0); set_btn(1, 0); tick(40);
        chk("mode_beats_start", int'(bus.mode), 2);
        chk("mode_beats_start_run_en", int'(bus.run_en), 0);

        hold(0, 40);
        chk("set_m_again", int'(bus.mode), 3);
        m0 = n_inc_m;
        set_btn(2, 1);
        tick(300);
        chk("inc_m_press", n_inc_m - m0, 1);
        rst = 1; tick(1); rst = 0;
        chk("rst_mode", int'(bus.mode), 0);
        chk("rst_run_en", int'(bus.run_en), 1);
        chk("rst_mask", int'(bus.blank_mask), 0);
        m0 = n_inc_m; h0 = n_inc_h;
        hold(0, 40);
        hold(0, 40);
        tick(600);
        chk("held_up_no_inc_m", n_inc_m - m0, 0);
        chk("held_up_no_inc_h", n_inc_h - h0, 0);
        set_btn(2, 0); tick(40);
        hold(2, 40);
        chk("repress_inc_m", n_inc_m - m0, 1);

        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rst = 1; tick($urandom_range(1, 3)); rst = 0;
            end else begin
                b = $urandom_range(0, 2);
                b2 = $urandom_range(0, 2);
                set_btn(b, 1);
                if (r == 1) set_btn(b2, 1);
                tick($urandom_range(0, 1) ? $urandom_range(1, 30) : $urandom_range(30, 600));
                set_btn(b, 0); set_btn(b2, 0);
            end
            tick($urandom_range(1, 80));
        end
        bus.btn_mode = 0; bus.btn_start = 0; bus.btn_up = 0;
        tick(100);
        while (exp_q.size() > 0) begin
            ev_t x;
            x = exp_q.pop_front();
            vectors++;
            errors++;
            $display("FAIL missing_event: got nothing, expected cyc=%0d mode=%0d clr=%0b inc_h=%0b inc_m=%0b mask=%h",
                     x.cyc, x.mode, x.clr, x.inc_h, x.inc_m, x.mask);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
